// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way write-back data cache controller.
package dcache_pkg;

    localparam int NUM_WAYS = 2;

    localparam logic DATA_SEL_CPU  = 1'b0;
    localparam logic DATA_SEL_PMEM = 1'b1;
    localparam logic ADDR_SEL_CPU  = 1'b0;
    localparam logic ADDR_SEL_WB   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Control FSM for the 2-way set-associative write-back data cache.
// Optional hit/miss performance counters are enabled with `define DCACHE_PERF_CNT_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic                lru_out,
    input  logic [NUM_WAYS-1:0] dirty_out,
    input  logic                pmem_resp,
    output logic                mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [NUM_WAYS-1:0] tag_load,
    output logic [NUM_WAYS-1:0] valid_load,
    output logic [NUM_WAYS-1:0] dirty_load,
    output logic                dirty_in,
    output logic                lru_load,
    output logic                lru_in,
    output logic [NUM_WAYS-1:0] data_we,
    output logic                data_sel,
    output logic                addr_sel
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
`endif
);

    dcache_state_t r_state;
    logic          r_victim;

    logic                w_req;
    logic                w_hit_any;
    logic                w_hit_way;
    logic [NUM_WAYS-1:0] w_hit_mask;
    logic [NUM_WAYS-1:0] w_victim_mask;

    assign w_req         = mem_read | mem_write;
    assign w_hit_any     = |hit;
    // Way 0 wins if the datapath ever reports both ways hitting.
    assign w_hit_way     = ~hit[0];
    assign w_hit_mask    = w_hit_way ? 2'b10 : 2'b01;
    assign w_victim_mask = r_victim ? 2'b10 : 2'b01;

    // NOTE: state uses non-blocking assignments and an asynchronous reset so that
    // an rst_n assertion forces IDLE (and silences every strobe) without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) r_state <= COMPARE;
                end
                COMPARE: begin
                    if (!w_req || w_hit_any) begin
                        r_state <= IDLE;
                    end else begin
                        r_victim <= lru_out;
                        r_state  <= dirty_out[lru_out] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) r_state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (pmem_resp) r_state <= COMPARE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tag_load   = '0;
        valid_load = '0;
        dirty_load = '0;
        dirty_in   = 1'b0;
        lru_load   = 1'b0;
        lru_in     = 1'b0;
        data_we    = '0;
        data_sel   = DATA_SEL_CPU;
        addr_sel   = ADDR_SEL_CPU;
        case (r_state)
            COMPARE: begin
                if (w_req && w_hit_any) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~w_hit_way;
                    if (mem_write) begin
                        data_we    = w_hit_mask;
                        data_sel   = DATA_SEL_CPU;
                        dirty_load = w_hit_mask;
                        dirty_in   = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = ADDR_SEL_WB;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                addr_sel  = ADDR_SEL_CPU;
                if (pmem_resp) begin
                    data_we    = w_victim_mask;
                    data_sel   = DATA_SEL_PMEM;
                    tag_load   = w_victim_mask;
                    valid_load = w_victim_mask;
                    dirty_load = w_victim_mask;
                    dirty_in   = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    if (1'b1) begin : g_perf_cnt
        logic             r_after_alloc;
        logic [CNT_W-1:0] r_hit_count;
        logic [CNT_W-1:0] r_miss_count;

        // The re-compare that closes a miss is not a genuine hit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_after_alloc <= 1'b0;
                r_hit_count   <= '0;
                r_miss_count  <= '0;
            end else begin
                r_after_alloc <= (r_state == ALLOCATE) && pmem_resp;
                if (r_state == COMPARE && w_req) begin
                    if (w_hit_any) begin
                        if (!r_after_alloc && r_hit_count != '1)
                            r_hit_count <= r_hit_count + 1'b1;
                    end else if (r_miss_count != '1) begin
                        r_miss_count <= r_miss_count + 1'b1;
                    end
                end
            end
        end

        assign hit_count  = r_hit_count;
        assign miss_count = r_miss_count;
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Control FSM for the 2-way set-associative write-back data cache. It sits between the CPU memory port and physical memory. It sequences the cache's per-set register arrays (tag, valid, dirty, LRU) and the data array through hit, writeback and allocate. It only consumes comparison results and array outputs from the datapath and drives every array load strobe and mux select; it holds no address or data itself.

## Interface
Parameters:
- CNT_W, 32, width of performance counters (used only with DCACHE_PERF_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- hit  in  2  per-way tag match AND valid, from datapath (combinational)
- lru_out  in  1  LRU way of the current set (0/1)
- dirty_out  in  2  per-way dirty bits of the current set
- pmem_resp  in  1  physical memory done, 1-cycle pulse
- mem_resp  out  1  CPU request complete, 1-cycle pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- tag_load, valid_load, dirty_load  out  2 each  per-way array load strobes
- dirty_in  out  1  value written to the dirty array
- lru_load  out  1  LRU array load strobe
- lru_in  out  1  new LRU way value
- data_we  out  2  per-way data-array write enable
- data_sel  out  1  data-array write source: 0 CPU, 1 pmem line
- addr_sel  out  1  pmem address: 0 CPU address, 1 victim tag + index
- hit_count, miss_count  out  CNT_W each  only with DCACHE_PERF_CNT_EN

## Operation
- Array contract: reads are combinational on the current index. Writes land at the next rising edge. A state entered after a load therefore sees the updated contents.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if mem_read|mem_write, go to COMPARE. Otherwise stay.
- COMPARE, hit (way w = index of the set hit bit): assert mem_resp. Set lru_load=1 and lru_in=~w.
  - On a write, also set data_we[w]=1, data_sel=0, dirty_load[w]=1, dirty_in=1.
  - Then go to IDLE.
- COMPARE, miss: victim v=lru_out. If dirty_out[v], go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK: pmem_write=1, addr_sel=1. On pmem_resp, go to ALLOCATE.
- ALLOCATE: pmem_read=1, addr_sel=0. On pmem_resp, set:
  - data_we[v]=1, data_sel=1
  - tag_load[v]=1, valid_load[v]=1
  - dirty_load[v]=1, dirty_in=0
  - Then go to COMPARE, where the access completes as a hit.
- Victim v is registered on COMPARE exit and is stable through WRITEBACK/ALLOCATE.
- Both hit bits set is illegal. Way 0 takes priority.
- mem_read and mem_write both set: treated as a write.
- Request dropped while in COMPARE: no loads; return to IDLE. Dropping a request in WRITEBACK/ALLOCATE is a protocol violation. The line operation still completes.
- All outputs are combinational from state plus inputs, except the counters.

## Timing
- Reset (any time, including mid-WRITEBACK/ALLOCATE): state goes to IDLE immediately. All strobes, pmem_read/pmem_write and mem_resp are 0. Counters are 0.
- Read/write hit: request seen in IDLE at edge N. mem_resp is high during cycle N+1 (COMPARE). Total latency is 2 cycles.
- Clean miss: COMPARE → ALLOCATE (k cycles until pmem_resp) → COMPARE (mem_resp). Latency is 3 + k.
- Dirty miss: adds WRITEBACK for j cycles. Latency is 4 + j + k.
- pmem_read and pmem_write are never asserted together. Each deasserts in the cycle after pmem_resp.
- mem_resp is never high for two consecutive cycles.

## Configuration
- DCACHE_PERF_CNT_EN defined: hit_count increments once per COMPARE hit that does not follow an ALLOCATE. miss_count increments once per COMPARE miss. Both counters saturate at all-ones.
- DCACHE_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Shared package dcache_pkg holds:
  - state enum dcache_state_t {IDLE, COMPARE, WRITEBACK, ALLOCATE}
  - localparams NUM_WAYS=2, DATA_SEL_CPU=0, DATA_SEL_PMEM=1, ADDR_SEL_CPU=0, ADDR_SEL_WB=1
- Single module, no sub-module. The optional counters live in a generate block in the same file.

## Test plan
- Reset: assert rst_n=0 mid-ALLOCATE with pmem_read=1 → pmem_read=0 in the same cycle; state IDLE; counters 0.
- Read hit: mem_read=1, hit=2'b01 → mem_resp in cycle 2; lru_load=1, lru_in=1; no data_we.
- Write hit way 1: mem_write=1, hit=2'b10 → data_we=2'b10, data_sel=0, dirty_load=2'b10, dirty_in=1, lru_in=0, mem_resp in cycle 2.
- Clean read miss: hit=0, lru_out=0, dirty_out=0, pmem_resp after 5 cycles → pmem_read held 5 cycles; tag/valid/data loads on way 0 with dirty_in=0; mem_resp at cycle 8.
- Dirty write miss: lru_out=1, dirty_out=2'b10 → pmem_write with addr_sel=1 until pmem_resp, then pmem_read; loads target way 1; final cycle writes CPU data with dirty_in=1.
- With DCACHE_PERF_CNT_EN: 3 hits + 2 misses → hit_count=3, miss_count=2.
